// File: rtl/regfile_16x32_if.sv
// Bus between the register-select decoder and the register file.
// The master side drives select, strobes and load data; the slave side returns the bus read.
interface regfile_16x32_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
);
    logic [NREGS-1:0] sel_onehot;
    logic             rin;
    logic             rout;
    logic             ba_out;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] bus_out;
    logic             bus_valid;
    logic             sel_err;
    logic [7:0]       wr_count;

    modport master (
        output sel_onehot, rin, rout, ba_out, wr_data,
        input  bus_out, bus_valid, sel_err, wr_count
    );

    modport slave (
        input  sel_onehot, rin, rout, ba_out, wr_data,
        output bus_out, bus_valid, sel_err, wr_count
    );
endinterface

// File: rtl/regfile_16x32.sv
// General-purpose register file R0..R(NREGS-1) addressed by a one-hot select,
// with a combinational OR-mux read path and R0 base-address gating.
module regfile_16x32 #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 16,
    parameter bit BYPASS = 1'b0
) (
    input logic             clk,
    input logic             clr,
    regfile_16x32_if.slave  rf
);
    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [7:0]       wr_count_q, wr_count_d;
    logic             sel_err_q, sel_err_d;

    logic             legal;
    logic [IDXW-1:0]  idx;
    logic             wr_en;
    logic             rd_en;
    logic             fwd;
    logic             gate_zero;
    logic [WIDTH-1:0] rd_mux;

    function automatic logic [IDXW-1:0] onehot_idx(input logic [NREGS-1:0] s);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (s[i]) r = r | IDXW'(i);
        end
        return r;
    endfunction

    always_comb begin
        legal = $onehot(rf.sel_onehot);
        idx   = onehot_idx(rf.sel_onehot);
        wr_en = rf.rin & legal;
        rd_en = rf.rout & legal;
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[idx] = rf.wr_data;
        wr_count_d = wr_count_q + {7'd0, wr_en};
        sel_err_d  = sel_err_q | ((rf.rin | rf.rout) & ~legal);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            wr_count_q <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
            sel_err_q  <= sel_err_d;
        end
    end

    // Each register drives the bus only when selected, so illegal or idle cycles read as 0.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_en && rf.sel_onehot[i]) rd_mux = rd_mux | regs_q[i];
        end
        fwd       = BYPASS && wr_en && !clr;
        gate_zero = !rd_en || (rf.sel_onehot[0] && rf.ba_out);
        if (gate_zero)  rf.bus_out = '0;
        else if (fwd)   rf.bus_out = rf.wr_data;
        else            rf.bus_out = rd_mux;
        rf.bus_valid = rd_en;
    end

    assign rf.sel_err  = sel_err_q;
    assign rf.wr_count = wr_count_q;
endmodule

// File: tb/tb_regfile_16x32.sv
// Randomized bench for regfile_16x32: one BYPASS=0 and one BYPASS=1 instance share stimulus
// and are compared every cycle against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile_16x32;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] sel = '0;
    logic        rin = 1'b0;
    logic        rout = 1'b0;
    logic        ba = 1'b0;
    logic [31:0] wdata = '0;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    logic [31:0] m_regs [16];
    int          m_cnt = 0;
    bit          m_err = 1'b0;

    regfile_16x32_if #(.WIDTH(32), .NREGS(16)) if0 ();
    regfile_16x32_if #(.WIDTH(32), .NREGS(16)) if1 ();

    assign if0.sel_onehot = sel;
    assign if0.rin        = rin;
    assign if0.rout       = rout;
    assign if0.ba_out     = ba;
    assign if0.wr_data    = wdata;
    assign if1.sel_onehot = sel;
    assign if1.rin        = rin;
    assign if1.rout       = rout;
    assign if1.ba_out     = ba;
    assign if1.wr_data    = wdata;

    regfile_16x32 #(.WIDTH(32), .NREGS(16), .BYPASS(1'b0)) dut0 (.clk(clk), .clr(clr), .rf(if0));
    regfile_16x32 #(.WIDTH(32), .NREGS(16), .BYPASS(1'b1)) dut1 (.clk(clk), .clr(clr), .rf(if1));

    always #5 clk = ~clk;

    initial for (int i = 0; i < 16; i++) m_regs[i] = '0;

    function automatic int sel_index(input logic [15:0] s);
        for (int i = 0; i < 16; i++) if (s[i]) return i;
        return 0;
    endfunction

    function automatic bit is_legal(input logic [15:0] s);
        return $countones(s) == 1;
    endfunction

    function automatic logic [31:0] exp_bus(input bit bypass);
        int k;
        if (!rout || !is_legal(sel)) return 32'h0;
        k = sel_index(sel);
        if (k == 0 && ba) return 32'h0;
        if (bypass && rin && !clr) return wdata;
        return m_regs[k];
    endfunction

    // Reference model: registers change only on committed writes, any clr wipes everything.
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            if ((rin || rout) && !is_legal(sel)) m_err = 1'b1;
            if (rin && is_legal(sel)) begin
                m_regs[sel_index(sel)] = wdata;
                m_cnt = (m_cnt + 1) % 256;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cmp_bus0",   if0.bus_out, exp_bus(1'b0));
            chk("cmp_bus1",   if1.bus_out, exp_bus(1'b1));
            chk("cmp_vld0",   {31'd0, if0.bus_valid}, {31'd0, rout && is_legal(sel)});
            chk("cmp_vld1",   {31'd0, if1.bus_valid}, {31'd0, rout && is_legal(sel)});
            chk("cmp_err0",   {31'd0, if0.sel_err}, {31'd0, m_err});
            chk("cmp_err1",   {31'd0, if1.sel_err}, {31'd0, m_err});
            chk("cmp_cnt0",   {24'd0, if0.wr_count}, 32'(m_cnt));
            chk("cmp_cnt1",   {24'd0, if1.wr_count}, 32'(m_cnt));
        end
    end

    task automatic drive(input logic [15:0] s, input logic wi, input logic ro,
                         input logic b, input logic [31:0] d);
        sel = s; rin = wi; rout = ro; ba = b; wdata = d;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    initial begin
        #12 clr = 1'b0;
        @(posedge clk); #1;
        run_cmp = 1'b1;

        drive(16'h0008, 0, 1, 0, 32'h0);
        @(negedge clk);
        chk("rst_bus", if0.bus_out, 32'h0);
        chk("rst_vld", {31'd0, if0.bus_valid}, 32'd1);
        chk("rst_err", {31'd0, if0.sel_err}, 32'd0);
        chk("rst_cnt", {24'd0, if0.wr_count}, 32'd0);
        nxt();

        drive(16'h0020, 1, 0, 0, 32'hDEADBEEF);
        nxt();
        drive(16'h0020, 0, 1, 0, 32'h0);
        @(negedge clk);
        chk("wr_rd_bus", if0.bus_out, 32'hDEADBEEF);
        chk("wr_rd_cnt", {24'd0, if0.wr_count}, 32'd1);
        chk("model_cnt", 32'(m_cnt), 32'd1);
        chk("model_r5", m_regs[5], 32'hDEADBEEF);
        nxt();
        drive(16'h0010, 0, 1, 0, 32'h0);
        @(negedge clk);
        chk("rd_r4", if0.bus_out, 32'h0);
        nxt();

        drive(16'h0001, 1, 0, 0, 32'h0000_1234);
        nxt();
        drive(16'h0001, 0, 1, 0, 32'h0);
        @(negedge clk);
        chk("r0_noba", if0.bus_out, 32'h0000_1234);
        nxt();
        drive(16'h0001, 0, 1, 1, 32'h0);
        @(negedge clk);
        chk("r0_ba_bus", if0.bus_out, 32'h0);
        chk("r0_ba_vld", {31'd0, if0.bus_valid}, 32'd1);
        nxt();
        drive(16'h0002, 1, 0, 0, 32'h0000_5678);
        nxt();
        drive(16'h0002, 0, 1, 1, 32'h0);
        @(negedge clk);
        chk("r1_ba", if0.bus_out, 32'h0000_5678);
        nxt();

        drive(16'h0006, 1, 0, 0, 32'hFFFFFFFF);
        nxt();
        drive(16'h0002, 0, 1, 0, 32'h0);
        @(negedge clk);
        chk("ill_err", {31'd0, if0.sel_err}, 32'd1);
        chk("ill_cnt", {24'd0, if0.wr_count}, 32'd3);
        chk("ill_r1", if0.bus_out, 32'h0000_5678);
        nxt();
        drive(16'h0004, 0, 1, 0, 32'h0);
        @(negedge clk);
        chk("ill_r2", if0.bus_out, 32'h0);
        nxt();
        drive(16'h0000, 0, 1, 0, 32'h0);
        @(negedge clk);
        chk("ill_rd_bus", if0.bus_out, 32'h0);
        chk("ill_rd_vld", {31'd0, if0.bus_valid}, 32'd0);
        nxt();

        drive(16'h0080, 1, 0, 0, 32'h11);
        nxt();
        drive(16'h0080, 1, 1, 0, 32'h22);
        @(negedge clk);
        chk("byp0_old", if0.bus_out, 32'h11);
        chk("byp1_new", if1.bus_out, 32'h22);
        nxt();
        drive(16'h0080, 0, 1, 0, 32'h0);
        @(negedge clk);
        chk("byp0_next", if0.bus_out, 32'h22);
        chk("err_sticky", {31'd0, if0.sel_err}, 32'd1);
        nxt();

        for (int n = 0; n < 400; n++) begin
            logic [15:0] s;
            if ($urandom_range(0, 9) < 8) s = 16'(1) << $urandom_range(0, 15);
            else s = 16'($urandom);
            drive(s, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            nxt();
        end

        drive(16'h0000, 0, 0, 0, 32'h0);
        clr = 1'b1;
        #3 clr = 1'b0;
        @(negedge clk);
        chk("clr_err", {31'd0, if0.sel_err}, 32'd0);
        nxt();
        for (int n = 0; n < 256; n++) begin
            drive(16'(1) << $urandom_range(0, 15), 1, 1'($urandom), 1'($urandom), $urandom);
            nxt();
        end
        drive(16'h0008, 1, 1, 0, 32'h0000_AAAA);
        @(negedge clk);
        chk("wrap_cnt0", {24'd0, if0.wr_count}, 32'd0);
        chk("wrap_cnt1", {24'd0, if1.wr_count}, 32'd0);
        chk("wrap_model", 32'(m_cnt), 32'd0);
        nxt();

        drive(16'h0008, 1, 1, 0, 32'h0000_AAAA);
        #2 clr = 1'b1;
        #1;
        chk("midclr_bus0", if0.bus_out, 32'h0);
        chk("midclr_bus1", if1.bus_out, 32'h0);
        chk("midclr_vld", {31'd0, if0.bus_valid}, 32'd1);
        chk("midclr_cnt", {24'd0, if0.wr_count}, 32'd0);
        nxt();
        rin = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sel = 16'(1) << i;
            #1;
            chk("clr_zero", if0.bus_out, 32'h0);
        end
        clr = 1'b0;
        sel = 16'h0008;
        @(negedge clk);
        chk("after_clr_r3", if0.bus_out, 32'h0);
        chk("after_clr_cnt", {24'd0, if0.wr_count}, 32'd0);
        nxt();
        run_cmp = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
